// File: rtl/prog_loader_gen.sv
// Writes an RV32I self-test program (operand load, ALU op, SW, NOPs, LW, JAL loop) into IMEM.
// Optional readback verification of the written program is enabled with `define LOADER_VERIFY_EN.
module prog_loader_gen #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [11:0] DMEM_OFF  = 12'h004,
    parameter int unsigned NOP_CNT   = 1,
    parameter int unsigned RS1       = 9,
    parameter int unsigned RS2       = 10,
    parameter int unsigned RD        = 11,
    parameter int unsigned RLD       = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [2:0]  alu_op_i,
    input  logic        imem_ready_i,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_wdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [4:0]  word_cnt_o
`ifdef LOADER_VERIFY_EN
    ,
    output logic        imem_re_o,
    input  logic [31:0] imem_rdata_i,
    output logic        verify_err_o,
    output logic [31:0] err_addr_o
`endif
);

    localparam int unsigned IDX_W    = 5;
    localparam logic [IDX_W-1:0] LW_IDX   = IDX_W'(NOP_CNT + 6);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOP_CNT + 7);
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [31:0] JAL_WORD = 32'h0000_006F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_VRD,
        S_VCMP
    } state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       op1_q;
    logic [31:0]       op2_q;
    logic [2:0]        alu_q;

    logic [31:0]       start_word;
    logic [31:0]       next_word;
    logic [31:0]       cur_word;

    // Program word at index idx; hi part is rounded up when lo's sign bit is set.
    function automatic logic [31:0] word_gen(input logic [IDX_W-1:0] idx,
                                             input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [2:0]  op);
        logic [19:0] hi_a;
        logic [19:0] hi_b;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] w;
        hi_a = a[31:12] + 20'(a[11]);
        hi_b = b[31:12] + 20'(b[11]);
        f7   = 7'b0000000;
        case (op)
            3'd0:    f3 = 3'b000;
            3'd1: begin
                f3 = 3'b000;
                f7 = 7'b0100000;
            end
            3'd2:    f3 = 3'b111;
            3'd3:    f3 = 3'b110;
            3'd4:    f3 = 3'b100;
            3'd5:    f3 = 3'b001;
            3'd6:    f3 = 3'b101;
            default: f3 = 3'b010;
        endcase
        w = NOP_WORD;
        if (idx == 5'd0)
            w = {hi_a, 5'(RS1), 7'b0110111};
        else if (idx == 5'd1)
            w = {a[11:0], 5'(RS1), 3'b000, 5'(RS1), 7'b0010011};
        else if (idx == 5'd2)
            w = {hi_b, 5'(RS2), 7'b0110111};
        else if (idx == 5'd3)
            w = {b[11:0], 5'(RS2), 3'b000, 5'(RS2), 7'b0010011};
        else if (idx == 5'd4)
            w = {f7, 5'(RS2), 5'(RS1), f3, 5'(RD), 7'b0110011};
        else if (idx == 5'd5)
            w = {DMEM_OFF[11:5], 5'(RD), 5'd0, 3'b010, DMEM_OFF[4:0], 7'b0100011};
        else if (idx < LW_IDX)
            w = NOP_WORD;
        else if (idx == LW_IDX)
            w = {DMEM_OFF, 5'd0, 3'b010, 5'(RLD), 7'b0000011};
        else
            w = JAL_WORD;
        return w;
    endfunction

    assign start_word = word_gen(5'd0, op1_i, op2_i, alu_op_i);
    assign next_word  = word_gen(idx_q + 5'd1, op1_q, op2_q, alu_q);
    assign cur_word   = word_gen(idx_q, op1_q, op2_q, alu_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            alu_q        <= '0;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= BASE_ADDR;
            imem_wdata_o <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            word_cnt_o   <= '0;
`ifdef LOADER_VERIFY_EN
            imem_re_o    <= 1'b0;
            verify_err_o <= 1'b0;
            err_addr_o   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op1_q        <= op1_i;
                        op2_q        <= op2_i;
                        alu_q        <= alu_op_i;
                        idx_q        <= '0;
                        busy_o       <= 1'b1;
                        done_o       <= 1'b0;
                        word_cnt_o   <= '0;
                        imem_we_o    <= 1'b1;
                        imem_addr_o  <= BASE_ADDR;
                        imem_wdata_o <= start_word;
                        state_q      <= S_EMIT;
`ifdef LOADER_VERIFY_EN
                        verify_err_o <= 1'b0;
                        err_addr_o   <= '0;
`endif
                    end
                end
                S_EMIT: begin
                    if (imem_ready_i) begin
                        word_cnt_o <= word_cnt_o + 5'd1;
                        if (idx_q == LAST_IDX) begin
                            imem_we_o <= 1'b0;
`ifdef LOADER_VERIFY_EN
                            idx_q       <= '0;
                            imem_re_o   <= 1'b1;
                            imem_addr_o <= BASE_ADDR;
                            state_q     <= S_VRD;
`else
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                            state_q <= S_IDLE;
`endif
                        end else begin
                            idx_q        <= idx_q + 5'd1;
                            imem_addr_o  <= imem_addr_o + 32'd4;
                            imem_wdata_o <= next_word;
                        end
                    end
                end
`ifdef LOADER_VERIFY_EN
                S_VRD: begin
                    imem_re_o <= 1'b0;
                    state_q   <= S_VCMP;
                end
                // Read data for imem_addr_o is valid this cycle; only the first mismatch is recorded.
                S_VCMP: begin
                    if ((imem_rdata_i != cur_word) && !verify_err_o) begin
                        verify_err_o <= 1'b1;
                        err_addr_o   <= imem_addr_o;
                    end
                    if (idx_q == LAST_IDX) begin
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        idx_q       <= idx_q + 5'd1;
                        imem_addr_o <= imem_addr_o + 32'd4;
                        imem_re_o   <= 1'b1;
                        state_q     <= S_VRD;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader_gen.sv
// Self-checking bench for prog_loader_gen: vector table, hand corner sequences and random runs
// against an arithmetic model of the generated program.
module tb_prog_loader_gen;

    localparam int unsigned N_WORDS = 9;
    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam int unsigned OFF     = 4;
    localparam int unsigned R1 = 9, R2 = 10, RDI = 11, RL = 12;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  alu_op;
    logic        imem_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic [4:0]  word_cnt;
`ifdef LOADER_VERIFY_EN
    logic        imem_re;
    logic [31:0] imem_rdata;
    logic        verify_err;
    logic [31:0] err_addr;
    logic [31:0] mem [0:31];
    bit          corrupt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t wr_log[$];

    logic [31:0] exp_prog [0:31];

    prog_loader_gen #(
        .BASE_ADDR(BASE), .DMEM_OFF(12'(OFF)), .NOP_CNT(1),
        .RS1(R1), .RS2(R2), .RD(RDI), .RLD(RL)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .op1_i(op1), .op2_i(op2),
        .alu_op_i(alu_op), .imem_ready_i(imem_ready), .imem_we_o(imem_we),
        .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata), .busy_o(busy),
        .done_o(done), .word_cnt_o(word_cnt)
`ifdef LOADER_VERIFY_EN
        , .imem_re_o(imem_re), .imem_rdata_i(imem_rdata),
        .verify_err_o(verify_err), .err_addr_o(err_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IMEM model: log every accepted write.
    always @(posedge clk) begin
        if (rst && imem_we && imem_ready) begin
            wr_log.push_back('{addr: imem_addr, data: imem_wdata});
`ifdef LOADER_VERIFY_EN
            mem[imem_addr[6:2]] <= imem_wdata;
`endif
        end
    end

`ifdef LOADER_VERIFY_EN
    always @(posedge clk) begin
        if (imem_re)
            imem_rdata <= mem[imem_addr[6:2]] ^ ((corrupt && imem_addr == 32'h10) ? 32'h1 : 32'h0);
        else
            imem_rdata <= 32'h0;
    end
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Reference program built from the instruction-format definitions.
    task automatic build_exp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        int unsigned f3_tab [8] = '{0, 0, 7, 6, 4, 1, 5, 2};
        logic [31:0] hi_a, hi_b, f7, f3;
        hi_a = ((a + 32'h800) >> 12) & 32'hFFFFF;
        hi_b = ((b + 32'h800) >> 12) & 32'hFFFFF;
        f7   = (op == 3'd1) ? 32'h20 : 32'h0;
        f3   = f3_tab[op];
        exp_prog[0] = (hi_a << 12) | (R1 << 7) | 32'h37;
        exp_prog[1] = ((a & 32'hFFF) << 20) | (R1 << 15) | (R1 << 7) | 32'h13;
        exp_prog[2] = (hi_b << 12) | (R2 << 7) | 32'h37;
        exp_prog[3] = ((b & 32'hFFF) << 20) | (R2 << 15) | (R2 << 7) | 32'h13;
        exp_prog[4] = (f7 << 25) | (R2 << 20) | (R1 << 15) | (f3 << 12) | (RDI << 7) | 32'h33;
        exp_prog[5] = ((OFF >> 5) << 25) | (RDI << 20) | (2 << 12) | ((OFF & 31) << 7) | 32'h23;
        exp_prog[6] = 32'h13;
        exp_prog[7] = (OFF << 20) | (2 << 12) | (RL << 7) | 32'h03;
        exp_prog[8] = 32'h6F;
    endtask

    task automatic chk_log(input int n);
        int m;
        m = (wr_log.size() < n) ? wr_log.size() : n;
        for (int i = 0; i < m; i++) begin
            chk($sformatf("addr[%0d]", i), wr_log[i].addr, BASE + 32'(4 * i));
            chk($sformatf("data[%0d]", i), wr_log[i].data, exp_prog[i]);
        end
    endtask

    task automatic run_prog(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input bit rnd_ready);
        bit finished;
        wr_log.delete();
        @(negedge clk);
        start = 1'b1; op1 = a; op2 = b; alu_op = op;
        imem_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(negedge clk);
        start = 1'b0;
        op1 = $urandom; op2 = $urandom; alu_op = 3'($urandom);
        chk("we_after_start", 32'(imem_we), 32'd1);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_cleared", 32'(done), 32'd0);
        finished = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (done) begin
                finished = 1'b1;
                break;
            end
            imem_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
        end
        imem_ready = 1'b0;
        if (!finished) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_timeout: done never rose, want done=1 within 300 cycles");
        end
        chk("done_end", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("we_end", 32'(imem_we), 32'd0);
        chk("word_cnt", 32'(word_cnt), N_WORDS);
        chk("log_len", wr_log.size(), N_WORDS);
        build_exp(a, b, op);
        chk_log(N_WORDS);
`ifdef LOADER_VERIFY_EN
        chk("verify_err", 32'(verify_err), corrupt ? 32'd1 : 32'd0);
`endif
    endtask

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  alu;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w4;
    } vec_t;

    initial begin
        vec_t tbl [4];
        logic [31:0] plan9 [9];

        tbl[0] = '{32'd5,     32'd3, 3'd0, 32'h000004B7, 32'h00548493, 32'h00A485B3};
        tbl[1] = '{32'h800,   32'd3, 3'd0, 32'h000014B7, 32'h80048493, 32'h00A485B3};
        tbl[2] = '{32'd5,     32'd3, 3'd1, 32'h000004B7, 32'h00548493, 32'h40A485B3};
        tbl[3] = '{32'd5,     32'd3, 3'd7, 32'h000004B7, 32'h00548493, 32'h00A4A5B3};
        plan9 = '{32'h000004B7, 32'h00548493, 32'h00000537, 32'h00350513, 32'h00A485B3,
                  32'h00B02223, 32'h00000013, 32'h00402603, 32'h0000006F};

        rst = 1'b0; start = 1'b0; op1 = '0; op2 = '0; alu_op = '0; imem_ready = 1'b0;
`ifdef LOADER_VERIFY_EN
        corrupt = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, BASE);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        rst = 1'b1;

        // Vector table, back to back without reset.
        for (int i = 0; i < 4; i++) begin
            run_prog(tbl[i].op1, tbl[i].op2, tbl[i].alu, 1'b0);
            if (wr_log.size() >= 5) begin
                chk($sformatf("tbl%0d_w0", i), wr_log[0].data, tbl[i].w0);
                chk($sformatf("tbl%0d_w1", i), wr_log[1].data, tbl[i].w1);
                chk($sformatf("tbl%0d_w4", i), wr_log[4].data, tbl[i].w4);
            end
            if (i == 0 && wr_log.size() == 9) begin
                for (int k = 0; k < 9; k++)
                    chk($sformatf("plan_w%0d", k), wr_log[k].data, plan9[k]);
            end
        end

        // Backpressure: hold ready low for 3 cycles while word 2 is presented.
        wr_log.delete();
        @(negedge clk);
        start = 1'b1; op1 = 32'd5; op2 = 32'd3; alu_op = 3'd0; imem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        imem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("bp_addr", imem_addr, 32'h8);
            chk("bp_data", imem_wdata, 32'h00000537);
            chk("bp_we", 32'(imem_we), 32'd1);
            if (c < 3) @(negedge clk);
        end
        imem_ready = 1'b1;
        for (int c = 0; c < 50 && !done; c++) @(negedge clk);
        imem_ready = 1'b0;
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_word_cnt", 32'(word_cnt), N_WORDS);
        chk("bp_log_len", wr_log.size(), N_WORDS);
        build_exp(32'd5, 32'd3, 3'd0);
        chk_log(N_WORDS);

        // Start while busy is ignored; reset mid-run aborts.
        wr_log.delete();
        @(negedge clk);
        start = 1'b1; op1 = 32'd5; op2 = 32'd3; alu_op = 3'd0; imem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_addr3", imem_addr, 32'hC);
        start = 1'b1; op1 = 32'hFFFF_FFFF; op2 = 32'h1234_5678; alu_op = 3'd4;
        @(negedge clk);
        start = 1'b0;
        chk("mid_addr4", imem_addr, 32'h10);
        chk("mid_w4", imem_wdata, 32'h00A485B3);
        @(negedge clk);
        chk("mid_addr5", imem_addr, 32'h14);
        rst = 1'b0;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("mrst_we", 32'(imem_we), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_addr", imem_addr, BASE);
        chk("mrst_word_cnt", 32'(word_cnt), 32'd0);
        chk("mrst_log_len", wr_log.size(), 32'd5);
        build_exp(32'd5, 32'd3, 3'd0);
        chk_log(5);
        rst = 1'b1;
        @(negedge clk);

        // Random operands, ops and backpressure.
        for (int r = 0; r < 25; r++)
            run_prog($urandom, $urandom, 3'($urandom), 1'b1);

`ifdef LOADER_VERIFY_EN
        corrupt = 1'b1;
        run_prog(32'd5, 32'd3, 3'd0, 1'b0);
        chk("verify_err_addr", err_addr, 32'h10);
        corrupt = 1'b0;
        run_prog(32'd7, 32'd9, 3'd2, 1'b0);
        chk("verify_err_cleared_addr", err_addr, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prog_loader_gen.md
Name: prog_loader_gen

Overview:
- Parametrised successor to the fixed single-test instruction loader.
- On a start pulse, latches two 32-bit operands and one of eight ALU ops, then writes a RISC-V RV32I self-test program into instruction memory.
- The program: materialise operands (LUI+ADDI), R-type op, SW result, configurable NOP bubble count, LW readback, terminal JAL loop.
- Sits between the test controller and the IMEM write port. Honours IMEM backpressure and supports repeated runs without reset.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of program word 0; must be 4-aligned.
- DMEM_OFF, 12'h004, signed 12-bit SW/LW offset from x0.
- NOP_CNT, 1, NOP words between SW and LW; legal range 0..15.
- RS1/RS2/RD/RLD, 9/10/11/12, register indices for op1, op2, result and loaded result.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start  in  1  1-cycle pulse; latches operands and begins a program write when idle
- op1  in  32  operand 1
- op2  in  32  operand 2
- alu_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT
- imem_ready  in  1  IMEM accepts the write this cycle
- imem_we  out  1  write valid
- imem_addr  out  32  byte address
- imem_wdata  out  32  instruction word
- busy  out  1  program write in progress
- done  out  1  level; set when the last word is accepted, cleared by the next accepted start
- word_cnt  out  5  number of words written in the last/current run

Behaviour:
- Reset (rst=0 at posedge): state IDLE; imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, word_cnt=0. Latched operands are cleared.
- Reset mid-run aborts immediately. The partially written program is left in IMEM.
- IDLE: start=1 latches op1/op2/alu_op, sets busy=1, clears done and word_cnt, and goes to EMIT with index 0.
  - The first imem_we assertion is the cycle after start.
  - start while busy is ignored, and the latched values are unchanged.
- EMIT: imem_we=1; imem_addr=BASE_ADDR+4*idx; imem_wdata=word(idx).
  - A word is accepted on a posedge with imem_we=1 and imem_ready=1. On acceptance, idx and word_cnt increment.
  - Without imem_ready, addr/wdata/we hold stable.
- Program words (N = 8+NOP_CNT):
  - idx0: LUI RS1, hi(op1)
  - idx1: ADDI RS1, RS1, lo(op1)
  - idx2: LUI RS2, hi(op2)
  - idx3: ADDI RS2, RS2, lo(op2)
  - idx4: R-type RD = RS1 op RS2
  - idx5: SW RD, DMEM_OFF(x0)
  - idx6..5+NOP_CNT: 32'h00000013
  - idx6+NOP_CNT: LW RLD, DMEM_OFF(x0)
  - idx7+NOP_CNT: 32'h0000006F
- Immediate split: lo = op[11:0]; hi = op[31:12] + op[11], modulo 2^20. This gives the LUI/ADDI sign-extension correction.
- R-type funct3/funct7 by alu_op: ADD 000/0000000, SUB 000/0100000, AND 111/0, OR 110/0, XOR 100/0, SLL 001/0, SRL 101/0, SLT 010/0.
- SW immediate: imm[11:5] goes to bits 31:25 and imm[4:0] to bits 11:7.
- After the last word is accepted, in the same posedge: imem_we=0, busy=0, done=1, and state returns to IDLE. imem_addr and imem_wdata hold their last values.
- With NOP_CNT=0, the LW immediately follows the SW.
- The next start restarts from idx0 and rewrites the same region.

Optional Feature:
- Macro LOADER_VERIFY_EN.
- Enabled:
  - Adds ports imem_re (out, 1), imem_rdata (in, 32, valid the cycle after imem_re), verify_err (out, 1) and err_addr (out, 32).
  - After the last write, enters VERIFY instead of IDLE. It reads back idx0..N-1, one word per 2 cycles, and compares against the regenerated word.
  - On the first mismatch: verify_err=1 and err_addr = the failing address. Comparison continues through all words.
  - busy stays 1 through VERIFY. done sets after the final compare.
  - verify_err and err_addr reset to 0 and clear on the next start.
- Disabled: none of these ports exist, and done sets on the last write acceptance.

Test Plan:
- op1=5, op2=3, ADD, imem_ready=1, BASE_ADDR=0 -> the first 9 writes are 0x000004B7 @0, 0x00548493 @4, 0x00000537 @8, 0x00350513 @C, 0x00A485B3 @10, 0x00B02223 @14, 0x00000013 @18, 0x00402603 @1C, 0x0000006F @20. done=1 the cycle after the last write; word_cnt=9.
- op1=32'h0000_0800 -> word0 0x000014B7 (hi rounded up); word1 0x80048493.
- alu_op=SUB then SLT on successive starts without reset -> word4 is 0x40A485B3, then 0x00A4A5B3. done clears on the second start.
- imem_ready held low for 3 cycles at idx2 -> addr 0x8 and data 0x00000537 stable throughout. No word is skipped or duplicated, and word_cnt still ends at 9.
- start pulsed at idx3, then rst=0 at idx5 -> the mid-run start is ignored. After reset: we=0, busy=0, done=0, addr=BASE_ADDR.
- LOADER_VERIFY_EN with imem_rdata forced wrong at idx4 -> verify_err=1, err_addr=0x10, done=1 after the 9th compare.
